// File: rtl/ram_sp_384x32_arb_pkg.sv
// Shared constants and requester encoding for the two-port SRAM arbiter.
// No logic. The ARB_BURST_EN build option also reads BURST_LEN from here.
package ram_sp_384x32_arb_pkg;

    localparam int unsigned ADR_WD    = 9;
    localparam int unsigned DAT_WD    = 32;
    localparam int unsigned DEPTH     = 384;
    localparam int unsigned BURST_LEN = 4;
    localparam int unsigned CNT_WD    = $clog2(BURST_LEN + 1);

    typedef enum logic {
        REQ_0 = 1'b0,
        REQ_1 = 1'b1
    } req_idx_e;

    function automatic logic [1:0] idx_onehot(input req_idx_e idx);
        return (idx == REQ_1) ? 2'b10 : 2'b01;
    endfunction

    function automatic logic adr_legal(input logic [ADR_WD-1:0] adr);
        return adr < ADR_WD'(DEPTH);
    endfunction

endpackage

// File: rtl/ram_sp_384x32_arb_rr2.sv
// Purpose: 2-way round-robin grant generator. Under ARB_BURST_EN the owner keeps priority for up to BURST_LEN grants.
// Latency: grant is combinational from req in the same cycle. Only the priority pointer is registered.
// Backpressure: a requester that is not granted holds its request. Nothing here stalls.
module ram_arb_rr2
    import ram_sp_384x32_arb_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [1:0] i_req,
    output logic [1:0] o_gnt
);

    req_idx_e    r_ptr;
    req_idx_e    w_ptr_nxt;
    logic [1:0]  w_gnt;
`ifdef ARB_BURST_EN
    logic [CNT_WD-1:0] r_cnt;
    logic [CNT_WD-1:0] w_cnt_nxt;
`endif

    always_comb begin
        w_gnt = 2'b00;
        if (!i_rst) begin
            case (i_req)
                2'b01:   w_gnt = 2'b01;
                2'b10:   w_gnt = 2'b10;
                2'b11:   w_gnt = idx_onehot(r_ptr);
                default: w_gnt = 2'b00;
            endcase
        end
    end

    assign o_gnt = w_gnt;

    always_comb begin
        w_ptr_nxt = r_ptr;
`ifdef ARB_BURST_EN
        w_cnt_nxt = r_cnt;
        // The owner keeps priority until it either stops getting grants or runs out its burst.
        if (w_gnt[r_ptr]) begin
            if (r_cnt == CNT_WD'(BURST_LEN - 1)) begin
                w_ptr_nxt = (r_ptr == REQ_0) ? REQ_1 : REQ_0;
                w_cnt_nxt = '0;
            end else begin
                w_cnt_nxt = r_cnt + 1'b1;
            end
        end else begin
            w_ptr_nxt = (r_ptr == REQ_0) ? REQ_1 : REQ_0;
            w_cnt_nxt = '0;
        end
`else
        if (|w_gnt) begin
            w_ptr_nxt = w_gnt[REQ_0] ? REQ_1 : REQ_0;
        end
`endif
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ptr <= REQ_0;
`ifdef ARB_BURST_EN
            r_cnt <= '0;
`endif
        end else begin
            r_ptr <= w_ptr_nxt;
`ifdef ARB_BURST_EN
            r_cnt <= w_cnt_nxt;
`endif
        end
    end

endmodule

// File: rtl/ram_sp_384x32_arb.sv
// Purpose: shares one 384x32 single-port SRAM between two requesters (round-robin; ARB_BURST_EN enables bursts).
// Latency: grant and SRAM drive in the request cycle; read data and err one cycle later.
// Backpressure: the loser of arbitration holds its command until gnt. Responses cannot be stalled.
module ram_sp_384x32_arb
    import ram_sp_384x32_arb_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        req_i,
    input  logic [1:0]        we_i,
    input  logic [ADR_WD-1:0] adr0_i,
    input  logic [ADR_WD-1:0] adr1_i,
    input  logic [DAT_WD-1:0] wdat0_i,
    input  logic [DAT_WD-1:0] wdat1_i,
    output logic [1:0]        gnt_o,
    output logic [1:0]        rvld_o,
    output logic [DAT_WD-1:0] rdat_o,
    output logic              err_o,
    output logic [ADR_WD-1:0] ram_adr_o,
    output logic              ram_wr_ena_o,
    output logic [DAT_WD-1:0] ram_wr_dat_o,
    output logic              ram_rd_ena_o,
    input  logic [DAT_WD-1:0] ram_rd_dat_i
);

    logic [1:0]        w_gnt;
    logic              w_any;
    req_idx_e          w_sel;
    logic              w_we;
    logic              w_legal;
    logic [ADR_WD-1:0] w_adr;
    logic [DAT_WD-1:0] w_wdat;
    logic [DAT_WD-1:0] w_rdat;

    logic              r_rd_vld;
    req_idx_e          r_rd_own;
    logic              r_rd_ill;
    logic              r_err;
    logic [DAT_WD-1:0] r_rdat_hold;

    ram_arb_rr2 u_rr2 (
        .i_clk (clk),
        .i_rst (rst),
        .i_req (req_i),
        .o_gnt (w_gnt)
    );

    assign gnt_o   = w_gnt;
    assign w_any   = |w_gnt;
    assign w_sel   = w_gnt[REQ_1] ? REQ_1 : REQ_0;
    assign w_we    = we_i[w_sel];
    assign w_adr   = (w_sel == REQ_1) ? adr1_i  : adr0_i;
    assign w_wdat  = (w_sel == REQ_1) ? wdat1_i : wdat0_i;
    assign w_legal = adr_legal(w_adr);

    // Illegal addresses are still granted so the requester drains; only the SRAM enables are suppressed.
    assign ram_adr_o    = w_any ? w_adr  : '0;
    assign ram_wr_dat_o = w_any ? w_wdat : '0;
    assign ram_wr_ena_o = w_any & w_legal &  w_we;
    assign ram_rd_ena_o = w_any & w_legal & ~w_we;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_vld    <= 1'b0;
            r_rd_own    <= REQ_0;
            r_rd_ill    <= 1'b0;
            r_err       <= 1'b0;
            r_rdat_hold <= '0;
        end else begin
            r_rd_vld <= w_any & ~w_we;
            r_rd_own <= w_sel;
            r_rd_ill <= ~w_legal;
            r_err    <= w_any & ~w_legal;
            if (r_rd_vld) begin
                r_rdat_hold <= w_rdat;
            end
        end
    end

    assign w_rdat = r_rd_ill ? '0 : ram_rd_dat_i;
    assign rdat_o = r_rd_vld ? w_rdat : r_rdat_hold;
    assign rvld_o = r_rd_vld ? idx_onehot(r_rd_own) : 2'b00;
    assign err_o  = r_err;

    a_gnt_onehot : assert property (@(posedge clk) $onehot0(gnt_o));
    a_ena_excl   : assert property (@(posedge clk) !(ram_wr_ena_o && ram_rd_ena_o));

endmodule

// File: tb/tb_ram_sp_384x32_arb.sv
// Scoreboard bench for ram_sp_384x32_arb with a behavioural SRAM and a reference memory/arbiter model.
module tb_ram_sp_384x32_arb;

    localparam int DEPTH_TB = 384;
    localparam int BURST_TB = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req_i = '0;
    logic [1:0]  we_i = '0;
    logic [8:0]  adr0_i = '0;
    logic [8:0]  adr1_i = '0;
    logic [31:0] wdat0_i = '0;
    logic [31:0] wdat1_i = '0;
    logic [1:0]  gnt_o;
    logic [1:0]  rvld_o;
    logic [31:0] rdat_o;
    logic        err_o;
    logic [8:0]  ram_adr_o;
    logic        ram_wr_ena_o;
    logic [31:0] ram_wr_dat_o;
    logic        ram_rd_ena_o;
    logic [31:0] ram_rd_dat_i = '0;

    always #5 clk = ~clk;

    ram_sp_384x32_arb dut (
        .clk          (clk),
        .rst          (rst),
        .req_i        (req_i),
        .we_i         (we_i),
        .adr0_i       (adr0_i),
        .adr1_i       (adr1_i),
        .wdat0_i      (wdat0_i),
        .wdat1_i      (wdat1_i),
        .gnt_o        (gnt_o),
        .rvld_o       (rvld_o),
        .rdat_o       (rdat_o),
        .err_o        (err_o),
        .ram_adr_o    (ram_adr_o),
        .ram_wr_ena_o (ram_wr_ena_o),
        .ram_wr_dat_o (ram_wr_dat_o),
        .ram_rd_ena_o (ram_rd_ena_o),
        .ram_rd_dat_i (ram_rd_dat_i)
    );

    // Behavioural SRAM: write in the enable cycle, read data one cycle after the read enable.
    logic [31:0] sram [0:511] = '{default: '0};
    always @(posedge clk) begin
        if (ram_wr_ena_o) sram[ram_adr_o] <= ram_wr_dat_o;
        if (ram_rd_ena_o) ram_rd_dat_i <= sram[ram_adr_o];
    end

    typedef struct {
        int          due;
        logic [1:0]  vld;
        logic [31:0] dat;
        logic        err;
    } rsp_t;

    rsp_t        q[$];
    rsp_t        mon_e;
    int          n_cmp = 0;
    int          n_fail = 0;
    int          cyc = 0;
    logic        rst_q;
    logic [31:0] last_rdat = '0;
    logic [31:0] ref_mem [0:511] = '{default: '0};
    int          ptr = 0;
    int          cnt = 0;
    logic [1:0]  last_g;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a response.
    always @(negedge clk) begin
        chk("ena_excl", 64'(ram_wr_ena_o & ram_rd_ena_o), 64'd0);
        if (rst_q === 1'b1) begin
            chk("rst_rvld", 64'(rvld_o), 64'd0);
            chk("rst_err", 64'(err_o), 64'd0);
            chk("rst_rdat", 64'(rdat_o), 64'd0);
            last_rdat = '0;
            while (q.size() > 0 && q[0].due <= cyc) void'(q.pop_front());
        end else if (rst_q === 1'b0) begin
            while (q.size() > 0 && q[0].due < cyc) begin
                chk("rsp_missing_due", 64'(cyc), 64'(q[0].due));
                void'(q.pop_front());
            end
            if (rvld_o != 2'b00 || err_o) begin
                if (q.size() == 0) begin
                    chk("rsp_unexpected", 64'({rvld_o, err_o}), 64'd0);
                end else begin
                    mon_e = q.pop_front();
                    chk("rsp_due", 64'(cyc), 64'(mon_e.due));
                    chk("rvld", 64'(rvld_o), 64'(mon_e.vld));
                    chk("err", 64'(err_o), 64'(mon_e.err));
                    if (mon_e.vld != 2'b00) begin
                        chk("rdat", 64'(rdat_o), 64'(mon_e.dat));
                        last_rdat = mon_e.dat;
                    end
                end
            end else begin
                chk("rdat_hold", 64'(rdat_o), 64'(last_rdat));
            end
        end
    end

    // One bus cycle: drive after the edge, then predict grant/SRAM drive from the model at the falling edge.
    task automatic step(input logic r, input logic [1:0] rq, input logic [1:0] w,
                        input logic [8:0] a0, input logic [8:0] a1,
                        input logic [31:0] d0, input logic [31:0] d1);
        logic [1:0]  eg;
        logic        s;
        logic [8:0]  a;
        logic [31:0] d;
        logic        wr;
        logic        legal;
        rsp_t        e;
        @(posedge clk);
        #1;
        rst = r; req_i = rq; we_i = w;
        adr0_i = a0; adr1_i = a1; wdat0_i = d0; wdat1_i = d1;
        @(negedge clk);
        eg = 2'b00;
        if (!r) begin
            if (rq == 2'b01)      eg = 2'b01;
            else if (rq == 2'b10) eg = 2'b10;
            else if (rq == 2'b11) eg = (ptr == 1) ? 2'b10 : 2'b01;
        end
        chk("gnt", 64'(gnt_o), 64'(eg));
        last_g = gnt_o;
        if (r) begin
            ptr = 0;
            cnt = 0;
        end else begin
`ifdef ARB_BURST_EN
            if (eg[ptr]) begin
                cnt++;
                if (cnt == BURST_TB) begin ptr = 1 - ptr; cnt = 0; end
            end else begin
                ptr = 1 - ptr;
                cnt = 0;
            end
`else
            if (eg != 2'b00) ptr = eg[0] ? 1 : 0;
`endif
        end
        if (eg != 2'b00) begin
            s     = eg[1];
            a     = s ? a1 : a0;
            d     = s ? d1 : d0;
            wr    = w[s];
            legal = (int'(a) < DEPTH_TB);
            chk("ram_wr_ena", 64'(ram_wr_ena_o), 64'(legal && wr));
            chk("ram_rd_ena", 64'(ram_rd_ena_o), 64'(legal && !wr));
            if (legal) chk("ram_adr", 64'(ram_adr_o), 64'(a));
            if (legal && wr) begin
                chk("ram_wr_dat", 64'(ram_wr_dat_o), 64'(d));
                ref_mem[a] = d;
            end
            if (!wr || !legal) begin
                e.due = cyc + 1;
                e.vld = wr ? 2'b00 : eg;
                e.dat = legal ? ref_mem[a] : 32'h0;
                e.err = !legal;
                q.push_back(e);
            end
        end else begin
            chk("ram_wr_ena_idle", 64'(ram_wr_ena_o), 64'd0);
            chk("ram_rd_ena_idle", 64'(ram_rd_ena_o), 64'd0);
        end
    endtask

    function automatic logic [8:0] rand_adr();
        int r;
        r = $urandom_range(0, 9);
        case (r)
            0:       return 9'($urandom_range(384, 511));
            1:       return 9'h000;
            2:       return 9'h17F;
            default: return 9'($urandom_range(0, 15));
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [1:0]  p_req;
        logic [1:0]  p_we;
        logic [8:0]  p_a [2];
        logic [31:0] p_d [2];
`ifdef ARB_BURST_EN
        logic [1:0]  seq [10] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b01};
        int          n_seq = 10;
`else
        logic [1:0]  seq [10] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
        int          n_seq = 4;
`endif

        // Reset with both requests high: no grants, no SRAM activity.
        for (int i = 0; i < 3; i++) step(1'b1, 2'b11, 2'b00, 9'h5, 9'h6, 32'h0, 32'h0);

        // Requester 0 writes then reads back.
        step(1'b0, 2'b01, 2'b01, 9'h005, 9'h000, 32'hDEADBEEF, 32'h0);
        step(1'b0, 2'b01, 2'b00, 9'h005, 9'h000, 32'h0, 32'h0);
        step(1'b0, 2'b00, 2'b00, 9'h000, 9'h000, 32'h0, 32'h0);

        // Contention from a freshly reset pointer.
        step(1'b1, 2'b00, 2'b00, 9'h0, 9'h0, 32'h0, 32'h0);
        for (int i = 0; i < n_seq; i++) begin
            step(1'b0, 2'b11, 2'b00, 9'h005, 9'(i), 32'h0, 32'h0);
            chk("contention_seq", 64'(last_g), 64'(seq[i]));
        end
        step(1'b0, 2'b00, 2'b00, 9'h0, 9'h0, 32'h0, 32'h0);

        // Illegal read from requester 1 and an illegal write from requester 0.
        step(1'b0, 2'b10, 2'b00, 9'h000, 9'h180, 32'h0, 32'h0);
        step(1'b0, 2'b01, 2'b01, 9'h1FF, 9'h000, 32'h55AA55AA, 32'h0);
        step(1'b0, 2'b00, 2'b00, 9'h0, 9'h0, 32'h0, 32'h0);

        // Boundary addresses.
        step(1'b0, 2'b01, 2'b01, 9'h000, 9'h000, 32'h12345678, 32'h0);
        step(1'b0, 2'b10, 2'b10, 9'h000, 9'h17F, 32'h0, 32'h9ABCDEF0);
        step(1'b0, 2'b01, 2'b00, 9'h000, 9'h000, 32'h0, 32'h0);
        step(1'b0, 2'b10, 2'b00, 9'h000, 9'h17F, 32'h0, 32'h0);
        step(1'b0, 2'b00, 2'b00, 9'h0, 9'h0, 32'h0, 32'h0);

        // Reset asserted while a read is requested: no response, priority back to requester 0.
        step(1'b1, 2'b01, 2'b00, 9'h005, 9'h000, 32'h0, 32'h0);
        step(1'b0, 2'b11, 2'b00, 9'h005, 9'h17F, 32'h0, 32'h0);
        chk("rst_prio", 64'(last_g), 64'(2'b01));
        step(1'b0, 2'b00, 2'b00, 9'h0, 9'h0, 32'h0, 32'h0);

        // Random traffic; an ungranted requester holds its command.
        p_req = 2'b00;
        p_we  = 2'b00;
        p_a[0] = '0; p_a[1] = '0; p_d[0] = '0; p_d[1] = '0;
        for (int k = 0; k < 600; k++) begin
            for (int n = 0; n < 2; n++) begin
                if (!p_req[n] && $urandom_range(0, 9) < 6) begin
                    p_req[n] = 1'b1;
                    p_we[n]  = 1'($urandom_range(0, 1));
                    p_a[n]   = rand_adr();
                    p_d[n]   = $urandom();
                end
            end
            step(1'b0, p_req, p_we, p_a[0], p_a[1], p_d[0], p_d[1]);
            p_req = p_req & ~last_g;
        end

        for (int i = 0; i < 3; i++) step(1'b0, 2'b00, 2'b00, 9'h0, 9'h0, 32'h0, 32'h0);
        chk("drain", 64'(q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
